// File: rtl/uart_msg_pkg.sv
// Shared constants, state encoding and header packing for the UART message encoders.
// No timing of its own; used by the encoder and its serialiser.
// Has no handshake of its own.
package uart_msg_pkg;

    localparam logic [5:0] MSG_ID_RECEIVED_NUM = 6'h05;
    localparam int         ADDR_W_DEF          = 8;
    localparam int         DATA_W_DEF          = 32;
    localparam int         PAYLOAD_BYTES       = (ADDR_W_DEF + DATA_W_DEF) / 8;
    localparam int         REPLACED_BIT        = 1;
    localparam int         OVERRUN_BIT         = 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CSUM
    } enc_state_t;

    function automatic logic [7:0] make_header(input logic replaced, input logic overrun);
        logic [7:0] h;
        h               = {MSG_ID_RECEIVED_NUM, 2'b00};
        h[REPLACED_BIT] = replaced;
        h[OVERRUN_BIT]  = overrun;
        return h;
    endfunction

endpackage

// File: rtl/msg_byte_serialiser.sv
// Loads a W-bit word and presents it one byte at a time, MSB byte first, flagging the last byte.
// Byte 0 is visible the cycle after load; each shift exposes the next byte one cycle later.
// Holds the current byte indefinitely while shift is low.
module msg_byte_serialiser #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic         shift,
    output logic [7:0]   byte_dat,
    output logic         last
);

    localparam int              NBYTES   = W / 8;
    localparam int              CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    logic [W-1:0]     word_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            word_q <= load_word;
            cnt_q  <= '0;
        end else if (shift) begin
            word_q <= word_q << 8;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign byte_dat = word_q[W-1 -: 8];
    assign last     = (cnt_q == LAST_IDX);

endmodule

// File: rtl/received_num_msg_encoder.sv
// Acks each received-number report and frames it as header + payload bytes (+ XOR checksum when MSG_CHECKSUM_EN is defined) for the UART tx.
// Header appears with the ack one cycle after valid is sampled in IDLE; one idle gap cycle between frames.
// tx_valid/tx_data hold steady while tx_ready is low; new reports wait (valid held) until the frame completes.
module received_num_msg_encoder
    import uart_msg_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PAYLOAD_W = ADDR_W + DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] mem_received_num,
    input  logic                 mem_received_valid,
    input  logic                 mem_received_replaced,
    input  logic                 mem_received_overrun,
    output logic                 mem_received_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);

    enc_state_t state_q, state_d;
    logic       capture, hdr_xfer, pay_xfer;
    logic [7:0] hdr_q, hdr_new;
    logic       ovr_flag_q;
    logic [7:0] pay_byte;
    logic       pay_last;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        hdr_xfer = 1'b0;
        pay_xfer = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_received_valid) begin
                    capture = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    hdr_xfer = 1'b1;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (tx_ready) begin
                    pay_xfer = 1'b1;
                    if (pay_last) begin
`ifdef MSG_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: begin
`ifdef MSG_CHECKSUM_EN
                if (tx_ready) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    // An overrun coinciding with capture is folded straight into this header.
    assign hdr_new = make_header(mem_received_replaced, ovr_flag_q | mem_received_overrun);

    // Only a header that actually carried the flag clears it, so an overrun arriving
    // while that header is stalled still reaches the next one; a new pulse always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_received_ack <= 1'b0;
            hdr_q            <= '0;
            ovr_flag_q       <= 1'b0;
        end else begin
            mem_received_ack <= capture;
            if (capture) hdr_q <= hdr_new;
            ovr_flag_q <= mem_received_overrun | (ovr_flag_q & ~(hdr_xfer & hdr_q[OVERRUN_BIT]));
        end
    end

    msg_byte_serialiser #(
        .W (PAYLOAD_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .load_word (mem_received_num),
        .shift     (pay_xfer),
        .byte_dat  (pay_byte),
        .last      (pay_last)
    );

`ifdef MSG_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst)           csum_q <= '0;
        else if (capture)  csum_q <= hdr_new;
        else if (pay_xfer) csum_q <= csum_q ^ pay_byte;
    end
`endif

    assign tx_valid = (state_q != IDLE);

    always_comb begin
        tx_data = '0;
        case (state_q)
            HDR:     tx_data = hdr_q;
            PAYLOAD: tx_data = pay_byte;
`ifdef MSG_CHECKSUM_EN
            CSUM:    tx_data = csum_q;
`endif
            default: tx_data = '0;
        endcase
    end

endmodule

// File: tb/tb_received_num_msg_encoder.sv
`timescale 1ns/1ps
module tb_received_num_msg_encoder;
    import uart_msg_pkg::*;

    localparam int NB = PAYLOAD_BYTES;
    localparam int PW = NB * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] mem_received_num = '0;
    logic          mem_received_valid = 1'b0;
    logic          mem_received_replaced = 1'b0;
    logic          mem_received_overrun = 1'b0;
    logic          mem_received_ack;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    received_num_msg_encoder dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_received_num      (mem_received_num),
        .mem_received_valid    (mem_received_valid),
        .mem_received_replaced (mem_received_replaced),
        .mem_received_overrun  (mem_received_overrun),
        .mem_received_ack      (mem_received_ack),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: bit 8 of each queued entry marks a header byte.
    // The encoder is idle exactly when no expected byte is outstanding; an overrun is
    // owed until a header that carried the flag has been transferred.
    logic [8:0] exp_q[$];
    logic       flag_m    = 1'b0;
    logic       exp_ack   = 1'b0;
    logic       armed     = 1'b0;
    logic       rst_prev  = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_dat = '0;

    always @(negedge clk) begin : mon
        logic       cap;
        logic       clr;
        logic [8:0] front;
        logic [7:0] h;
        logic [7:0] b;
        logic [7:0] cs;
        if (armed) begin
            check("ack", 40'(mem_received_ack), 40'(exp_ack));
            check("tx_valid", 40'(tx_valid), 40'(exp_q.size() != 0));
            if (rst_prev) check("tx_data_after_rst", 40'(tx_data), 40'(0));
            if (stall_prev) begin
                check("stall_valid", 40'(tx_valid), 40'(1));
                check("stall_data", 40'(tx_data), 40'(stall_dat));
            end
        end
        if (rst) begin
            exp_q.delete();
            flag_m     = 1'b0;
            exp_ack    = 1'b0;
            stall_prev = 1'b0;
            rst_prev   = 1'b1;
            armed      = 1'b1;
        end else if (armed) begin
            rst_prev = 1'b0;
            clr      = 1'b0;
            cap      = mem_received_valid && (exp_q.size() == 0);
            if (tx_valid && tx_ready && exp_q.size() != 0) begin
                front = exp_q.pop_front();
                check("tx_byte", 40'(tx_data), 40'(front[7:0]));
                if (front[8] && front[OVERRUN_BIT]) clr = 1'b1;
            end
            if (cap) begin
                h = 8'(int'(MSG_ID_RECEIVED_NUM) * 4 + int'(mem_received_replaced) * 2
                       + int'(flag_m | mem_received_overrun));
                exp_q.push_back({1'b1, h});
                cs = h;
                for (int i = 0; i < NB; i++) begin
                    b = 8'(mem_received_num >> (8 * (NB - 1 - i)));
                    exp_q.push_back({1'b0, b});
                    cs = cs ^ b;
                end
`ifdef MSG_CHECKSUM_EN
                exp_q.push_back({1'b0, cs});
`endif
            end
            exp_ack    = cap;
            flag_m     = mem_received_overrun | (flag_m & ~clr);
            stall_prev = tx_valid && !tx_ready;
            stall_dat  = tx_data;
        end
    end

    int ready_mode = 0;
    bit rand_ovr   = 1'b0;
    int cyc        = 0;

    task automatic step();
        @(posedge clk);
        #1;
        mem_received_overrun = rand_ovr && ($urandom_range(0, 7) == 0);
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
    endtask

    task automatic send_msg(input logic [7:0] a, input logic [31:0] d, input logic rep, input int hold);
        int n = 0;
        mem_received_num      = {a, d};
        mem_received_replaced = rep;
        mem_received_valid    = 1'b1;
        do begin
            step();
            n++;
        end while (!mem_received_ack && n < 300);
        if (!mem_received_ack) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected one", n);
        end
        repeat (hold) step();
        mem_received_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Plain frame, always ready
        ready_mode = 0;
        send_msg(8'd4, 32'd1, 1'b1, 0);
        wait_idle();

        // Ready one cycle in three
        ready_mode = 1;
        send_msg(8'd3, 32'd2, 1'b0, 0);
        wait_idle();

        // Overrun while idle, then two messages
        ready_mode = 0;
        mem_received_overrun = 1'b1;
        step();
        send_msg(8'd2, 32'd3, 1'b0, 0);
        wait_idle();
        send_msg(8'd7, 32'hdeadbeef, 1'b1, 0);
        wait_idle();

        // Overrun coinciding with the header transfer
        send_msg(8'h11, 32'h22334455, 1'b0, 0);
        mem_received_overrun = 1'b1;
        step();
        wait_idle();
        send_msg(8'h66, 32'h778899aa, 1'b1, 0);
        wait_idle();

        // Valid held three cycles past the ack
        send_msg(8'h5a, 32'h0badf00d, 1'b0, 3);
        wait_idle();

        // Reset while the second payload byte is on the bus
        send_msg(8'hc3, 32'h12345678, 1'b1, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle();
        send_msg(8'h3c, 32'h87654321, 1'b0, 0);
        wait_idle();

        // Back-to-back reports with the gap cycle between frames
        send_msg(8'hff, 32'hffffffff, 1'b1, 0);
        send_msg(8'h00, 32'h00000000, 1'b0, 0);
        wait_idle();

        // Randomised traffic with stalls and overrun pulses
        for (int k = 0; k < 40; k++) begin
            ready_mode = $urandom_range(0, 2);
            rand_ovr   = 1'($urandom_range(0, 1));
            send_msg(8'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        rand_ovr   = 1'b0;
        ready_mode = 0;
        wait_idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
